// File: rtl/mup_int_pkg.sv
// rtl/mup_int_pkg.sv - shared types and default sizing for the interrupt controller
package mup_int_pkg;

  localparam int N_SRC_DEF   = 8;
  localparam int VEC_W_DEF   = 4;
  localparam int ACK_TMO_DEF = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/mup_int_ctrl_if.sv
// rtl/mup_int_ctrl_if.sv - request, mask and CPU handshake bundle of the interrupt controller
interface mup_int_ctrl_if
  import mup_int_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF,
  parameter int VEC_W = VEC_W_DEF
);

  logic             en;
  logic [N_SRC-1:0] irq;
  logic             mask_we;
  logic [N_SRC-1:0] mask_din;
  logic             int_ack;
  logic             eoi;
  logic             int_req;
  logic [VEC_W-1:0] vec;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] in_service;
  logic             tmo_err;

  modport master (
    output en, irq, mask_we, mask_din, int_ack, eoi,
    input  int_req, vec, pending, in_service, tmo_err
  );

  modport slave (
    input  en, irq, mask_we, mask_din, int_ack, eoi,
    output int_req, vec, pending, in_service, tmo_err
  );

endinterface

// File: rtl/mup_prio_enc.sv
// rtl/mup_prio_enc.sv - fixed-priority encoder, lowest set index wins
module mup_prio_enc
  import mup_int_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF,
  parameter int VEC_W = VEC_W_DEF
) (
  input  logic [N_SRC-1:0] req,
  output logic             valid,
  output logic [VEC_W-1:0] idx
);

  // Scan from the top so the lowest index is the last assignment and wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = VEC_W'(i);
      end
    end
  end

endmodule

// File: rtl/mup_int_ctrl.sv
// rtl/mup_int_ctrl.sv - priority interrupt controller: edge capture, mask, select, ack/eoi sequencing
module mup_int_ctrl
  import mup_int_pkg::*;
#(
  parameter int N_SRC   = N_SRC_DEF,
  parameter int VEC_W   = VEC_W_DEF,
  parameter int ACK_TMO = ACK_TMO_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  mup_int_ctrl_if.slave bus
);

  state_t           state;
  logic [N_SRC-1:0] irq_q;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] in_service;
  logic [VEC_W-1:0] vec;
  logic             int_req;
  logic             tmo_err;
  logic [7:0]       cnt;

  logic [N_SRC-1:0] edge_det;
  logic [N_SRC-1:0] cand;
  logic [N_SRC-1:0] vec_oh;
  logic [N_SRC-1:0] clr_mask;
  logic             win_valid;
  logic [VEC_W-1:0] win_idx;
  logic             ack_take;
  logic [7:0]       cnt_nxt;

  assign edge_det = bus.irq & ~irq_q;
  assign cand     = pending & ~mask;
  assign vec_oh   = N_SRC'(1) << vec;
  assign ack_take = (state == REQ) && bus.int_ack;
  assign clr_mask = ack_take ? vec_oh : '0;
  assign cnt_nxt  = cnt + 8'd1;

  mup_prio_enc #(
    .N_SRC (N_SRC),
    .VEC_W (VEC_W)
  ) u_prio_enc (
    .req   (cand),
    .valid (win_valid),
    .idx   (win_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= '0;
      mask  <= '1;
    end else begin
      irq_q <= bus.irq;
      if (bus.mask_we) begin
        mask <= bus.mask_din;
      end
    end
  end

  // A fresh edge on the bit being acknowledged is OR'd in after the clear so it survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | edge_det;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      int_req    <= 1'b0;
      vec        <= '0;
      in_service <= '0;
      tmo_err    <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.en && win_valid) begin
            state   <= REQ;
            vec     <= win_idx;
            int_req <= 1'b1;
            cnt     <= '0;
          end
        end
        REQ: begin
          if (bus.int_ack) begin
            state      <= SERVICE;
            int_req    <= 1'b0;
            in_service <= vec_oh;
          end else if (cnt_nxt == 8'(ACK_TMO)) begin
            state   <= IDLE;
            int_req <= 1'b0;
            tmo_err <= 1'b1;
            cnt     <= cnt_nxt;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        SERVICE: begin
          if (bus.eoi) begin
            state      <= IDLE;
            in_service <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          int_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus.int_req    = int_req;
  assign bus.vec        = vec;
  assign bus.pending    = pending;
  assign bus.in_service = in_service;
  assign bus.tmo_err    = tmo_err;

endmodule

// File: tb/tb_mup_int_ctrl.sv
// tb/tb_mup_int_ctrl.sv - self-checking bench for the priority interrupt controller
module tb_mup_int_ctrl;
  import mup_int_pkg::*;

  localparam int NS  = 8;
  localparam int VW  = 4;
  localparam int TMO = 15;

  typedef struct {
    logic [NS-1:0] irq;
    logic          mwe;
    logic [NS-1:0] mdin;
    logic          en;
    logic          ack;
    logic          eoi;
    logic          e_int;
    logic [VW-1:0] e_vec;
    logic [NS-1:0] e_pend;
    logic [NS-1:0] e_ins;
    logic          e_tmo;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  mup_int_ctrl_if #(.N_SRC(NS), .VEC_W(VW)) bus ();

  mup_int_ctrl #(.N_SRC(NS), .VEC_W(VW), .ACK_TMO(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic vec_t mk(int irq, int mwe, int mdin, int en, int ack, int eoi,
                              int e_int, int e_vec, int e_pend, int e_ins, int e_tmo);
    vec_t v;
    v.irq = NS'(irq); v.mwe = 1'(mwe); v.mdin = NS'(mdin); v.en = 1'(en);
    v.ack = 1'(ack); v.eoi = 1'(eoi); v.e_int = 1'(e_int); v.e_vec = VW'(e_vec);
    v.e_pend = NS'(e_pend); v.e_ins = NS'(e_ins); v.e_tmo = 1'(e_tmo);
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(logic [NS-1:0] irq, logic ack, logic eoi);
    bus.irq = irq; bus.int_ack = ack; bus.eoi = eoi; bus.mask_we = 1'b0;
  endtask

  task automatic chk_out(string tag, logic e_int, logic [VW-1:0] e_vec,
                         logic [NS-1:0] e_pend, logic [NS-1:0] e_ins, logic e_tmo);
    chk({tag, ".int"}, 32'(bus.int_req), 32'(e_int));
    chk({tag, ".vec"}, 32'(bus.vec), 32'(e_vec));
    chk({tag, ".pending"}, 32'(bus.pending), 32'(e_pend));
    chk({tag, ".in_service"}, 32'(bus.in_service), 32'(e_ins));
    chk({tag, ".tmo_err"}, 32'(bus.tmo_err), 32'(e_tmo));
  endtask

  initial begin
    int hi;
    vec_t e;
    bus.en = 1'b0; bus.irq = '0; bus.mask_we = 1'b0; bus.mask_din = '0;
    bus.int_ack = 1'b0; bus.eoi = 1'b0;

    //            irq  mwe mdin en ack eoi | int vec pend ins tmo
    tbl.push_back(mk(8'h00, 1, 8'h00, 1, 0, 0,  0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(8'h08, 0, 0, 1, 0, 0,  0, 0, 8'h08, 8'h00, 0));
    tbl.push_back(mk(8'h00, 0, 0, 1, 0, 0,  1, 3, 8'h08, 8'h00, 0));
    tbl.push_back(mk(8'h00, 0, 0, 1, 1, 0,  0, 3, 8'h00, 8'h08, 0));
    tbl.push_back(mk(8'h00, 0, 0, 1, 0, 0,  0, 3, 8'h00, 8'h08, 0));
    tbl.push_back(mk(8'h00, 0, 0, 1, 0, 1,  0, 3, 8'h00, 8'h00, 0));
    tbl.push_back(mk(8'h22, 0, 0, 1, 0, 0,  0, 3, 8'h22, 8'h00, 0));
    tbl.push_back(mk(8'h00, 0, 0, 1, 0, 0,  1, 1, 8'h22, 8'h00, 0));
    tbl.push_back(mk(8'h00, 0, 0, 1, 1, 0,  0, 1, 8'h20, 8'h02, 0));
    tbl.push_back(mk(8'h00, 0, 0, 1, 0, 1,  0, 1, 8'h20, 8'h00, 0));
    tbl.push_back(mk(8'h00, 0, 0, 1, 0, 0,  1, 5, 8'h20, 8'h00, 0));
    tbl.push_back(mk(8'h00, 0, 0, 1, 1, 0,  0, 5, 8'h00, 8'h20, 0));
    tbl.push_back(mk(8'h00, 0, 0, 1, 0, 1,  0, 5, 8'h00, 8'h00, 0));
    tbl.push_back(mk(8'h00, 1, 8'h04, 1, 0, 0,  0, 5, 8'h00, 8'h00, 0));
    tbl.push_back(mk(8'h04, 0, 0, 1, 0, 0,  0, 5, 8'h04, 8'h00, 0));
    tbl.push_back(mk(8'h00, 0, 0, 1, 0, 0,  0, 5, 8'h04, 8'h00, 0));
    tbl.push_back(mk(8'h00, 1, 8'h00, 1, 0, 0,  0, 5, 8'h04, 8'h00, 0));
    tbl.push_back(mk(8'h00, 0, 0, 1, 0, 0,  1, 2, 8'h04, 8'h00, 0));
    tbl.push_back(mk(8'h00, 0, 0, 1, 1, 0,  0, 2, 8'h00, 8'h04, 0));
    tbl.push_back(mk(8'h00, 0, 0, 1, 0, 1,  0, 2, 8'h00, 8'h00, 0));
    tbl.push_back(mk(8'h08, 0, 0, 1, 0, 0,  0, 2, 8'h08, 8'h00, 0));
    tbl.push_back(mk(8'h00, 0, 0, 1, 0, 0,  1, 3, 8'h08, 8'h00, 0));
    tbl.push_back(mk(8'h08, 0, 0, 1, 1, 0,  0, 3, 8'h08, 8'h08, 0));
    tbl.push_back(mk(8'h00, 0, 0, 1, 1, 0,  0, 3, 8'h08, 8'h08, 0));
    tbl.push_back(mk(8'h00, 0, 0, 1, 0, 1,  0, 3, 8'h08, 8'h00, 0));
    tbl.push_back(mk(8'h00, 0, 0, 1, 0, 0,  1, 3, 8'h08, 8'h00, 0));
    tbl.push_back(mk(8'h00, 0, 0, 1, 0, 1,  1, 3, 8'h08, 8'h00, 0));
    tbl.push_back(mk(8'h00, 0, 0, 1, 1, 0,  0, 3, 8'h00, 8'h08, 0));
    tbl.push_back(mk(8'h00, 0, 0, 1, 0, 1,  0, 3, 8'h00, 8'h00, 0));
    tbl.push_back(mk(8'h01, 0, 0, 0, 0, 0,  0, 3, 8'h01, 8'h00, 0));
    tbl.push_back(mk(8'h00, 0, 0, 0, 0, 0,  0, 3, 8'h01, 8'h00, 0));
    tbl.push_back(mk(8'h00, 0, 0, 1, 0, 0,  1, 0, 8'h01, 8'h00, 0));
    tbl.push_back(mk(8'h00, 0, 0, 0, 1, 0,  0, 0, 8'h00, 8'h01, 0));
    tbl.push_back(mk(8'h00, 0, 0, 0, 0, 1,  0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(8'h00, 0, 0, 1, 0, 0,  0, 0, 8'h00, 8'h00, 0));

    #12;
    chk_out("reset", 1'b0, '0, '0, '0, 1'b0);
    rst_n = 1'b1;
    step();
    chk_out("post_reset", 1'b0, '0, '0, '0, 1'b0);

    foreach (tbl[i]) begin
      bus.irq = tbl[i].irq; bus.mask_we = tbl[i].mwe; bus.mask_din = tbl[i].mdin;
      bus.en = tbl[i].en; bus.int_ack = tbl[i].ack; bus.eoi = tbl[i].eoi;
      sb.push_back(tbl[i]);
      step();
      e = sb.pop_front();
      chk_out($sformatf("row%0d", i), e.e_int, e.e_vec, e.e_pend, e.e_ins, e.e_tmo);
    end
    drv('0, 1'b0, 1'b0);
    bus.en = 1'b1;

    // Re-trigger of the in-service source plus a higher one; no nesting.
    drv(8'h10, 0, 0); step();
    drv(8'h00, 0, 0); step(); chk_out("nest_raise4", 1, 4, 8'h10, 8'h00, 0);
    drv(8'h00, 1, 0); step(); chk_out("nest_ack4", 0, 4, 8'h00, 8'h10, 0);
    drv(8'h11, 0, 0); step();
    drv(8'h00, 0, 0); step(); chk_out("nest_hold", 0, 4, 8'h11, 8'h10, 0);
    drv(8'h00, 0, 1); step(); chk_out("nest_eoi", 0, 4, 8'h11, 8'h00, 0);
    drv(8'h00, 0, 0); step(); chk_out("nest_raise0", 1, 0, 8'h11, 8'h00, 0);
    drv(8'h00, 1, 0); step();
    drv(8'h00, 0, 1); step();
    drv(8'h00, 0, 0); step(); chk_out("nest_raise4b", 1, 4, 8'h10, 8'h00, 0);
    drv(8'h00, 1, 0); step();
    drv(8'h00, 0, 1); step(); chk_out("nest_done", 0, 4, 8'h00, 8'h00, 0);

    // Ack timeout, re-raise, then ack landing on the expiry cycle.
    drv(8'h01, 0, 0); step();
    drv(8'h00, 0, 0); step(); chk_out("tmo_raise", 1, 0, 8'h01, 8'h00, 0);
    hi = 1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.int_req) hi++;
      else break;
    end
    chk("tmo_high_cycles", 32'(hi), 32'(TMO));
    chk_out("tmo_expired", 0, 0, 8'h01, 8'h00, 1);
    step(); chk_out("tmo_reraise", 1, 0, 8'h01, 8'h00, 1);
    repeat (TMO - 1) step();
    chk("tmo_still_high", 32'(bus.int_req), 32'd1);
    drv(8'h00, 1, 0); step(); chk_out("tmo_ack_wins", 0, 0, 8'h00, 8'h01, 1);
    drv(8'h00, 0, 1); step(); chk_out("tmo_sticky", 0, 0, 8'h00, 8'h00, 1);

    // Asynchronous reset while int is raised.
    drv(8'h02, 0, 0); step();
    drv(8'h00, 0, 0); step(); chk_out("rst_pre", 1, 1, 8'h02, 8'h00, 1);
    #2 rst_n = 1'b0;
    #1 chk_out("rst_async", 0, 0, 8'h00, 8'h00, 0);
    step();
    rst_n = 1'b1;
    drv(8'h04, 0, 0); step();
    drv(8'h00, 0, 0); step(); step(); step();
    chk_out("rst_mask_ones", 0, 0, 8'h04, 8'h00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
